mux_nto1_reg: RTL

//   Parametrised N:1, W-bit registered multiplexer with valid/ready handshake.
//   It is the successor to the gate-level 2:1 mux. It adds per-channel streams,
//   a registered output, and two selection modes: fixed (external select) and

---
 rtl/mux_nto1_reg.sv | 113 +++++++++++
 1 files changed

// File: rtl/mux_nto1_reg.sv
// mux_nto1_reg: N:1, W-bit registered multiplexer with valid/ready streams.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_data    N packed channels; channel i at [i*W +: W]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, at most one bit high)
//   sel        fixed-mode channel select (ignored when MODE = 1)
//   out_data   registered output data
//   out_valid  registered output valid
//   out_ready  consumer ready
//   out_sel    source channel of the current out_data
// MODE 0 forwards the channel picked by sel; MODE 1 round-robins over the
// valid channels, starting the search at the channel after the last winner.
module mux_nto1_reg #(
    parameter  int unsigned N    = 4,
    parameter  int unsigned W    = 8,
    parameter  int unsigned MODE = 0,
    localparam int unsigned SW   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [SW-1:0]    sel,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SW-1:0]    out_sel
);

    logic          load;
    logic          grant_vld;
    logic [SW-1:0] grant_idx;
    logic [W-1:0]  grant_data;
    logic [SW-1:0] ptr;
    logic [W-1:0]  ch_data [N];

    // Unpack the flat input bus into one word per channel.
    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign ch_data[g] = in_data[g*W +: W];
    end

    // Output register is free, or is being drained this cycle.
    assign load = !out_valid || out_ready;

    // Grant selection; sel values >= N never match any channel.
    always_comb begin : grant_logic
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        if (MODE == 0) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (sel == SW'(i) && in_valid[SW'(i)]) begin
                    grant_vld  = 1'b1;
                    grant_idx  = SW'(i);
                    grant_data = ch_data[SW'(i)];
                end
            end
        end else begin
            // Search ptr..N-1 first, then wrap around to 0..ptr-1.
            for (int unsigned i = 0; i < N; i++) begin
                if (!grant_vld && in_valid[SW'(i)] && SW'(i) >= ptr) begin
                    grant_vld  = 1'b1;
                    grant_idx  = SW'(i);
                    grant_data = ch_data[SW'(i)];
                end
            end
            for (int unsigned i = 0; i < N; i++) begin
                if (!grant_vld && in_valid[SW'(i)] && SW'(i) < ptr) begin
                    grant_vld  = 1'b1;
                    grant_idx  = SW'(i);
                    grant_data = ch_data[SW'(i)];
                end
            end
        end
    end

    // Fixed mode offers ready on sel even without valid; round-robin only on the winner.
    always_comb begin : ready_logic
        in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (MODE == 0) begin
                in_ready[SW'(i)] = load && (sel == SW'(i));
            end else begin
                in_ready[SW'(i)] = load && grant_vld && (grant_idx == SW'(i));
            end
        end
    end

    // Output register and round-robin pointer; both hold while stalled.
    always_ff @(posedge clk or posedge rst) begin : out_reg
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (grant_vld) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_sel   <= grant_idx;
                if (MODE != 0) begin
                    ptr <= (grant_idx == SW'(N-1)) ? '0 : grant_idx + SW'(1);
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
